dmem_access_unit: RTL and testbench

- Sequential data-memory access controller for the RV32I core's MEM stage.
- Accepts load/store requests from the pipeline, runs a valid/ready transaction on the data-memory bus, and stalls the pipeline until the transaction completes.
- Aligns and masks store data.
- Captures read data plus load attributes, registered, for the downstream load-extraction unit.

---
 rtl/dmem_access_unit_pkg.sv | 23 ++
 rtl/dmem_access_unit_store_align.sv | 28 ++
 rtl/dmem_access_unit.sv | 124 ++++++++++++
 tb/tb_dmem_access_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// access-size encodings, FSM states and the alignment check.
package dmem_access_unit_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_RESP  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  // Sizes 10 and 11 both decode as word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    if (size == SIZE_BYTE) return 1'b0;
    if (size == SIZE_HALF) return addr_lo[0];
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_access_unit_store_align.sv
// Store-data lane replication and byte-strobe generation for one request.
module store_align
  import dmem_access_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] data,
  output logic [3:0]  mask
);

  always_comb begin
    data = wdata;
    mask = 4'b1111;
    case (size)
      SIZE_BYTE: begin
        data = {4{wdata[7:0]}};
        mask = 4'b0001 << addr_lo;
      end
      SIZE_HALF: begin
        data = {2{wdata[15:0]}};
        mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Sequential load/store controller: runs one valid/ready bus transaction per
// accepted request, stalls the pipeline meanwhile, and registers load results.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_valid_in,
  input  logic        req_load_in,
  input  logic        req_store_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  input  logic [1:0]  req_size_in,
  input  logic        req_unsigned_in,
  output logic        stall_out,
  output logic        done_out,
  output logic        misaligned_out,
  output logic        timeout_out,
  output logic        dm_valid_out,
  input  logic        dm_ready_in,
  output logic        dm_wr_out,
  output logic [31:0] dm_addr_out,
  output logic [31:0] dm_wdata_out,
  output logic [3:0]  dm_wmask_out,
  input  logic [31:0] dm_rdata_in,
  output logic [31:0] dmdata_out,
  output logic [1:0]  addr_1_to_0_out,
  output logic        load_unsigned_out,
  output logic [1:0]  load_size_out
);

  state_t      state;
  logic [31:0] tmo_cnt;
  logic [1:0]  addr_lo_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] al_data;
  logic [3:0]  al_mask;
  logic        accept;

  // Gated by reset so stall_out reads 0 while reset is held.
  assign accept    = !rst_in && (state != ST_BUSY) && req_valid_in && (req_load_in || req_store_in);
  assign stall_out = (state == ST_BUSY) || accept;

  store_align u_store_align (
    .addr_lo (req_addr_in[1:0]),
    .size    (req_size_in),
    .wdata   (req_wdata_in),
    .data    (al_data),
    .mask    (al_mask)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= ST_IDLE;
      tmo_cnt           <= '0;
      addr_lo_q         <= '0;
      size_q            <= '0;
      uns_q             <= 1'b0;
      done_out          <= 1'b0;
      misaligned_out    <= 1'b0;
      timeout_out       <= 1'b0;
      dm_valid_out      <= 1'b0;
      dm_wr_out         <= 1'b0;
      dm_addr_out       <= '0;
      dm_wdata_out      <= '0;
      dm_wmask_out      <= '0;
      dmdata_out        <= '0;
      addr_1_to_0_out   <= '0;
      load_unsigned_out <= 1'b0;
      load_size_out     <= '0;
    end else begin
      done_out       <= 1'b0;
      misaligned_out <= 1'b0;
      timeout_out    <= 1'b0;
      case (state)
        ST_BUSY: begin
          // Ready wins over timeout when both land in the same cycle.
          if (dm_ready_in) begin
            state        <= ST_RESP;
            dm_valid_out <= 1'b0;
            done_out     <= 1'b1;
            if (!dm_wr_out) begin
              dmdata_out        <= dm_rdata_in;
              addr_1_to_0_out   <= addr_lo_q;
              load_size_out     <= size_q;
              load_unsigned_out <= uns_q;
            end
          end else if (TIMEOUT_CYCLES != 0 && tmo_cnt == TIMEOUT_CYCLES - 1) begin
            state        <= ST_FAULT;
            dm_valid_out <= 1'b0;
            timeout_out  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        default: begin
          if (accept) begin
            if (is_misaligned(req_size_in, req_addr_in[1:0])) begin
              state          <= ST_FAULT;
              misaligned_out <= 1'b1;
            end else begin
              state        <= ST_BUSY;
              tmo_cnt      <= '0;
              dm_valid_out <= 1'b1;
              dm_wr_out    <= !req_load_in;
              dm_addr_out  <= {req_addr_in[31:2], 2'b00};
              dm_wdata_out <= al_data;
              dm_wmask_out <= req_load_in ? 4'b0000 : al_mask;
              addr_lo_q    <= req_addr_in[1:0];
              size_q       <= req_size_in;
              uns_q        <= req_unsigned_in;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit; inputs change just after the falling
// edge, outputs are sampled 1ns later, the DUT acts on the rising edge.
module tb_dmem_access_unit;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        req_valid_in = 1'b0, req_load_in = 1'b0, req_store_in = 1'b0;
  logic [31:0] req_addr_in = '0, req_wdata_in = '0;
  logic [1:0]  req_size_in = '0;
  logic        req_unsigned_in = 1'b0;
  logic        stall_out, done_out, misaligned_out, timeout_out;
  logic        dm_valid_out, dm_ready_in = 1'b0, dm_wr_out;
  logic [31:0] dm_addr_out, dm_wdata_out, dm_rdata_in = '0, dmdata_out;
  logic [3:0]  dm_wmask_out;
  logic [1:0]  addr_1_to_0_out, load_size_out;
  logic        load_unsigned_out;

  int vecs = 0;
  int errs = 0;

  always #5 clk_in = ~clk_in;

  dmem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid_in(req_valid_in), .req_load_in(req_load_in), .req_store_in(req_store_in),
    .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in), .req_size_in(req_size_in),
    .req_unsigned_in(req_unsigned_in),
    .stall_out(stall_out), .done_out(done_out), .misaligned_out(misaligned_out),
    .timeout_out(timeout_out), .dm_valid_out(dm_valid_out), .dm_ready_in(dm_ready_in),
    .dm_wr_out(dm_wr_out), .dm_addr_out(dm_addr_out), .dm_wdata_out(dm_wdata_out),
    .dm_wmask_out(dm_wmask_out), .dm_rdata_in(dm_rdata_in), .dmdata_out(dmdata_out),
    .addr_1_to_0_out(addr_1_to_0_out), .load_unsigned_out(load_unsigned_out),
    .load_size_out(load_size_out)
  );

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic issue(input logic ld, input logic st, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wd);
    req_valid_in = 1'b1; req_load_in = ld; req_store_in = st; req_addr_in = addr;
    req_size_in = size; req_unsigned_in = uns; req_wdata_in = wd;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step(); step(); #1;
    vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL rst_stall got %b exp 0", stall_out); end
    vecs++; if (dm_valid_out !== 1'b0) begin errs++; $display("FAIL rst_valid got %b exp 0", dm_valid_out); end
    vecs++; if ({done_out, misaligned_out, timeout_out} !== 3'b000) begin errs++; $display("FAIL rst_pulses got %b exp 000", {done_out, misaligned_out, timeout_out}); end
    vecs++; if (dmdata_out !== 32'h0) begin errs++; $display("FAIL rst_dmdata got %h exp 0", dmdata_out); end
    step(); rst_in = 1'b0;
  endtask

  task automatic test_lw();
    step(); issue(1, 0, 32'h100, 2'b10, 0, 32'h0); #1;
    vecs++; if (stall_out !== 1'b1) begin errs++; $display("FAIL lw_accept_stall got %b exp 1", stall_out); end
    step(); req_valid_in = 1'b0; dm_ready_in = 1'b1; dm_rdata_in = 32'hDEADBEEF; #1;
    vecs++; if (dm_valid_out !== 1'b1) begin errs++; $display("FAIL lw_busy_valid got %b exp 1", dm_valid_out); end
    vecs++; if (dm_addr_out !== 32'h100) begin errs++; $display("FAIL lw_addr got %h exp 100", dm_addr_out); end
    vecs++; if ({dm_wr_out, dm_wmask_out} !== 5'b0_0000) begin errs++; $display("FAIL lw_wr_mask got %b exp 00000", {dm_wr_out, dm_wmask_out}); end
    vecs++; if ({stall_out, done_out} !== 2'b10) begin errs++; $display("FAIL lw_busy_stall_done got %b exp 10", {stall_out, done_out}); end
    step(); dm_ready_in = 1'b0; dm_rdata_in = 32'h0; #1;
    vecs++; if ({done_out, stall_out, dm_valid_out} !== 3'b100) begin errs++; $display("FAIL lw_resp got %b exp 100", {done_out, stall_out, dm_valid_out}); end
    vecs++; if (dmdata_out !== 32'hDEADBEEF) begin errs++; $display("FAIL lw_dmdata got %h exp deadbeef", dmdata_out); end
    vecs++; if ({addr_1_to_0_out, load_size_out, load_unsigned_out} !== 5'b00_10_0) begin errs++; $display("FAIL lw_attr got %b exp 00100", {addr_1_to_0_out, load_size_out, load_unsigned_out}); end
    step(); #1;
    vecs++; if (done_out !== 1'b0) begin errs++; $display("FAIL lw_done_pulse got %b exp 0", done_out); end
  endtask

  task automatic test_sb();
    step(); issue(0, 1, 32'h203, 2'b00, 0, 32'h000000A5);
    step(); req_valid_in = 1'b0; dm_ready_in = 1'b1; dm_rdata_in = 32'h11111111; #1;
    vecs++; if (dm_wdata_out !== 32'hA5A5A5A5) begin errs++; $display("FAIL sb_wdata got %h exp a5a5a5a5", dm_wdata_out); end
    vecs++; if (dm_wmask_out !== 4'b1000) begin errs++; $display("FAIL sb_mask got %b exp 1000", dm_wmask_out); end
    vecs++; if (dm_addr_out !== 32'h200) begin errs++; $display("FAIL sb_addr got %h exp 200", dm_addr_out); end
    vecs++; if ({dm_wr_out, dm_valid_out} !== 2'b11) begin errs++; $display("FAIL sb_wr_valid got %b exp 11", {dm_wr_out, dm_valid_out}); end
    step(); dm_ready_in = 1'b0; #1;
    vecs++; if (done_out !== 1'b1) begin errs++; $display("FAIL sb_done got %b exp 1", done_out); end
    vecs++; if (dmdata_out !== 32'hDEADBEEF) begin errs++; $display("FAIL sb_dmdata_kept got %h exp deadbeef", dmdata_out); end
  endtask

  task automatic test_half_word_masks();
    // SH to upper half, then LW+store flag combination treated as a load.
    step(); issue(0, 1, 32'h802, 2'b01, 0, 32'h0000BEEF);
    step(); req_valid_in = 1'b0; dm_ready_in = 1'b1; #1;
    vecs++; if ({dm_wdata_out, dm_wmask_out} !== {32'hBEEFBEEF, 4'b1100}) begin errs++; $display("FAIL sh_data_mask got %h/%b exp beefbeef/1100", dm_wdata_out, dm_wmask_out); end
    step(); dm_ready_in = 1'b0;
    issue(1, 1, 32'h900, 2'b11, 0, 32'h0);
    step(); req_valid_in = 1'b0; dm_ready_in = 1'b1; dm_rdata_in = 32'h5A5A0001; #1;
    vecs++; if ({dm_wr_out, dm_wmask_out} !== 5'b0_0000) begin errs++; $display("FAIL ldst_as_load got %b exp 00000", {dm_wr_out, dm_wmask_out}); end
    step(); dm_ready_in = 1'b0; #1;
    vecs++; if ({dmdata_out, load_size_out} !== {32'h5A5A0001, 2'b11}) begin errs++; $display("FAIL ldst_capture got %h/%b exp 5a5a0001/11", dmdata_out, load_size_out); end
  endtask

  task automatic test_misaligned();
    logic seen_valid;
    seen_valid = 1'b0;
    step(); issue(1, 0, 32'h101, 2'b01, 0, 32'h0); #1;
    vecs++; if (stall_out !== 1'b1) begin errs++; $display("FAIL mis_accept_stall got %b exp 1", stall_out); end
    step(); req_valid_in = 1'b0; #1;
    seen_valid |= dm_valid_out;
    vecs++; if ({misaligned_out, stall_out, done_out} !== 3'b100) begin errs++; $display("FAIL mis_fault got %b exp 100", {misaligned_out, stall_out, done_out}); end
    step(); #1;
    seen_valid |= dm_valid_out;
    vecs++; if (misaligned_out !== 1'b0) begin errs++; $display("FAIL mis_pulse got %b exp 0", misaligned_out); end
    vecs++; if (seen_valid !== 1'b0) begin errs++; $display("FAIL mis_no_bus got %b exp 0", seen_valid); end
  endtask

  task automatic test_back_to_back();
    step(); issue(1, 0, 32'h302, 2'b00, 1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(); req_valid_in = 1'b0; #1;
      vecs++; if ({dm_valid_out, stall_out} !== 2'b11) begin errs++; $display("FAIL b2b_wait%0d got %b exp 11", i, {dm_valid_out, stall_out}); end
    end
    step(); dm_ready_in = 1'b1; dm_rdata_in = 32'hCAFEF00D;
    step(); dm_ready_in = 1'b0; issue(0, 1, 32'h400, 2'b10, 0, 32'h12345678); #1;
    vecs++; if ({done_out, stall_out} !== 2'b11) begin errs++; $display("FAIL b2b_resp got %b exp 11", {done_out, stall_out}); end
    vecs++; if (dmdata_out !== 32'hCAFEF00D) begin errs++; $display("FAIL b2b_dmdata got %h exp cafef00d", dmdata_out); end
    vecs++; if ({addr_1_to_0_out, load_size_out, load_unsigned_out} !== 5'b10_00_1) begin errs++; $display("FAIL b2b_attr got %b exp 10001", {addr_1_to_0_out, load_size_out, load_unsigned_out}); end
    step(); req_valid_in = 1'b0; dm_ready_in = 1'b1; #1;
    vecs++; if ({dm_valid_out, dm_wr_out, dm_wmask_out} !== 6'b11_1111) begin errs++; $display("FAIL b2b_sw_bus got %b exp 111111", {dm_valid_out, dm_wr_out, dm_wmask_out}); end
    vecs++; if ({dm_addr_out, dm_wdata_out} !== {32'h400, 32'h12345678}) begin errs++; $display("FAIL b2b_sw_addr_data got %h/%h exp 400/12345678", dm_addr_out, dm_wdata_out); end
    step(); dm_ready_in = 1'b0; #1;
    vecs++; if ({done_out, stall_out, dmdata_out} !== {2'b10, 32'hCAFEF00D}) begin errs++; $display("FAIL b2b_sw_done got %b/%h exp 10/cafef00d", {done_out, stall_out}, dmdata_out); end
  endtask

  task automatic test_timeout();
    logic seen_done;
    seen_done = 1'b0;
    step(); issue(0, 1, 32'h500, 2'b10, 0, 32'hFFFF0000);
    for (int i = 0; i < 4; i++) begin
      step(); req_valid_in = 1'b0; #1;
      seen_done |= done_out;
      vecs++; if ({dm_valid_out, timeout_out} !== 2'b10) begin errs++; $display("FAIL tmo_busy%0d got %b exp 10", i, {dm_valid_out, timeout_out}); end
    end
    step(); #1;
    seen_done |= done_out;
    vecs++; if ({timeout_out, dm_valid_out, stall_out} !== 3'b100) begin errs++; $display("FAIL tmo_fault got %b exp 100", {timeout_out, dm_valid_out, stall_out}); end
    step(); #1;
    seen_done |= done_out;
    vecs++; if ({timeout_out, seen_done} !== 2'b00) begin errs++; $display("FAIL tmo_after got %b exp 00", {timeout_out, seen_done}); end
  endtask

  task automatic test_reset_mid_busy();
    step(); issue(1, 0, 32'h600, 2'b10, 0, 32'h0);
    step(); #1;
    vecs++; if (dm_valid_out !== 1'b1) begin errs++; $display("FAIL rmb_busy got %b exp 1", dm_valid_out); end
    #1 rst_in = 1'b1; #1;
    vecs++; if ({dm_valid_out, stall_out, done_out} !== 3'b000) begin errs++; $display("FAIL rmb_ctrl got %b exp 000", {dm_valid_out, stall_out, done_out}); end
    vecs++; if ({dm_addr_out, dmdata_out} !== 64'h0) begin errs++; $display("FAIL rmb_data got %h/%h exp 0/0", dm_addr_out, dmdata_out); end
    req_valid_in = 1'b0;
    step(); rst_in = 1'b0;
    step(); issue(1, 0, 32'h700, 2'b10, 0, 32'h0);
    step(); req_valid_in = 1'b0; dm_ready_in = 1'b1; dm_rdata_in = 32'h0BADF00D; #1;
    vecs++; if ({dm_valid_out, dm_addr_out} !== {1'b1, 32'h700}) begin errs++; $display("FAIL rmb_next_bus got %b/%h exp 1/700", dm_valid_out, dm_addr_out); end
    step(); dm_ready_in = 1'b0; #1;
    vecs++; if ({done_out, dmdata_out} !== {1'b1, 32'h0BADF00D}) begin errs++; $display("FAIL rmb_next_done got %b/%h exp 1/0badf00d", done_out, dmdata_out); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sb();
    test_half_word_masks();
    test_misaligned();
    test_back_to_back();
    test_timeout();
    test_reset_mid_busy();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
